cpu_mem_arbiter: RTL and testbench

//  Shares one single-port memory between IF-stage fetch and MEM-stage load/store of the 5-stage core.

---
 rtl/cpu_mem_arb_pkg.sv | 21 ++
 rtl/cpu_mem_arbiter_if.sv | 41 ++++
 rtl/cpu_mem_arb_perf.sv | 42 ++++
 rtl/cpu_mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_mem_arb_pkg.sv
// Shared types and default widths for the CPU memory arbiter.
// Optional performance counters are enabled with the macro CPU_MEM_ARB_PERF_EN.
package cpu_mem_arb_pkg;

   localparam int ADDR_W_DEFAULT = 32;
   localparam int DATA_W_DEFAULT = 32;

   // Arbiter transaction phase: choose a requester, present the request, await the response.
   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } arb_state_e;

   // Which pipeline side owns the single outstanding memory transaction.
   typedef enum logic {
      OWN_IM,
      OWN_DM
   } arb_owner_e;

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Downstream single-port memory bus seen by the arbiter.
// The master side issues one request at a time; the slave grants it and returns one response.
interface cpu_mem_arbiter_if
   import cpu_mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
);

   logic                  mem_req;
   logic                  mem_gnt;
   logic                  mem_we;
   logic [DATA_W/8-1:0]   mem_wstrb;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  mem_rvalid;
   logic [DATA_W-1:0]     mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_wstrb,
      output mem_addr,
      output mem_wdata,
      input  mem_gnt,
      input  mem_rvalid,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_wstrb,
      input  mem_addr,
      input  mem_wdata,
      output mem_gnt,
      output mem_rvalid,
      output mem_rdata
   );

endinterface

// File: rtl/cpu_mem_arb_perf.sv
// Free-running performance counters for the CPU memory arbiter: fetch stall cycles,
// data stall cycles and completed memory responses. 32-bit, wrapping.
// Only compiled when CPU_MEM_ARB_PERF_EN is defined.
`ifdef CPU_MEM_ARB_PERF_EN
module cpu_mem_arb_perf
   import cpu_mem_arb_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        im_stall,
   input  logic        dm_stall,
   input  logic        rvalid,
   output logic [31:0] perf_im_stall_cnt,
   output logic [31:0] perf_dm_stall_cnt,
   output logic [31:0] perf_xact_cnt
);

   logic [2:0] inc;

   assign inc = {rvalid, dm_stall, im_stall};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
         logic [31:0] cnt_reg;

         // Count one per cycle the matching event is high; natural wrap at 2^32.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               cnt_reg <= '0;
            end else if (inc[gi]) begin
               cnt_reg <= cnt_reg + 32'd1;
            end
         end
      end
   endgenerate

   assign perf_im_stall_cnt = g_cnt[0].cnt_reg;
   assign perf_dm_stall_cnt = g_cnt[1].cnt_reg;
   assign perf_xact_cnt     = g_cnt[2].cnt_reg;

endmodule
`endif

// File: rtl/cpu_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store.
// One transaction outstanding at a time, data side has fixed priority over fetch.
// Completed responses are held (im_have/dm_have) until the whole pipeline advances.
// Define CPU_MEM_ARB_PERF_EN to add the perf_* counter outputs.
module cpu_mem_arbiter
   import cpu_mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   // instruction fetch side
   input  logic                 im_req,
   input  logic [ADDR_W-1:0]    im_addr,
   input  logic                 im_kill,
   output logic [DATA_W-1:0]    im_rdata,
   output logic                 im_stall,
   // data load/store side
   input  logic                 dm_req,
   input  logic                 dm_we,
   input  logic [DATA_W/8-1:0]  dm_wstrb,
   input  logic [ADDR_W-1:0]    dm_addr,
   input  logic [DATA_W-1:0]    dm_wdata,
   output logic [DATA_W-1:0]    dm_rdata,
   output logic                 dm_stall,
   // downstream memory
   cpu_mem_arbiter_if.master    mem
`ifdef CPU_MEM_ARB_PERF_EN
   ,
   output logic [31:0]          perf_im_stall_cnt,
   output logic [31:0]          perf_dm_stall_cnt,
   output logic [31:0]          perf_xact_cnt
`endif
);

   localparam int STRB_W = DATA_W / 8;

   arb_state_e          state_reg;
   arb_state_e          state_next;
   arb_owner_e          owner_reg;

   logic                mem_we_reg;
   logic [STRB_W-1:0]   mem_wstrb_reg;
   logic [ADDR_W-1:0]   mem_addr_reg;
   logic [DATA_W-1:0]   mem_wdata_reg;

   logic [DATA_W-1:0]   im_rdata_reg;
   logic [DATA_W-1:0]   dm_rdata_reg;
   logic                im_have_reg;
   logic                im_have_next;
   logic                dm_have_reg;
   logic                dm_have_next;
   logic                kill_pend_reg;
   logic                kill_pend_next;

   logic                pick_dm;
   logic                pick_im;
   logic                advance;
   logic                im_xact;
   logic                im_discard;
   logic                launch;
   logic                rsp_take;
   logic                mem_req_c;

   // A side wants memory only while its pipeline stage is waiting on a fresh result;
   // a killed fetch is not worth starting.
   assign pick_dm    = dm_req & ~dm_have_reg;
   assign pick_im    = im_req & ~im_have_reg & ~im_kill;

   assign im_stall   = im_req & ~im_have_reg;
   assign dm_stall   = dm_req & ~dm_have_reg;
   assign advance    = ~im_stall & ~dm_stall;

   // A fetch in flight belongs to the old instruction stream once a kill has been seen.
   assign im_xact    = (state_reg != IDLE) && (owner_reg == OWN_IM);
   assign im_discard = kill_pend_reg | im_kill;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state: IDLE -> REQ on any pending side, REQ -> WAIT on grant, WAIT -> IDLE on response.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (pick_dm || pick_im) state_next = REQ;
         REQ:     if (mem.mem_gnt)        state_next = WAIT;
         WAIT:    if (mem.mem_rvalid)     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs: request strobe, field-capture enable, response-accept enable.
   always_comb begin
      mem_req_c = 1'b0;
      launch    = 1'b0;
      rsp_take  = 1'b0;
      case (state_reg)
         IDLE:    launch    = pick_dm | pick_im;
         REQ:     mem_req_c = 1'b1;
         WAIT:    rsp_take  = mem.mem_rvalid;
         default: ;
      endcase
   end

   // Capture owner and request fields once per transaction; data side wins a tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_reg     <= OWN_IM;
         mem_we_reg    <= 1'b0;
         mem_wstrb_reg <= '0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
      end else if (launch) begin
         if (pick_dm) begin
            owner_reg     <= OWN_DM;
            mem_we_reg    <= dm_we;
            mem_wstrb_reg <= dm_wstrb;
            mem_addr_reg  <= dm_addr;
            mem_wdata_reg <= dm_wdata;
         end else begin
            owner_reg     <= OWN_IM;
            mem_we_reg    <= 1'b0;
            mem_wstrb_reg <= '0;
            mem_addr_reg  <= im_addr;
            mem_wdata_reg <= '0;
         end
      end
   end

   // Result-held flags and kill bookkeeping; a response landing this cycle overrides the advance clear.
   always_comb begin
      im_have_next   = im_have_reg;
      dm_have_next   = dm_have_reg;
      kill_pend_next = kill_pend_reg;
      if (advance) begin
         im_have_next = 1'b0;
         dm_have_next = 1'b0;
      end
      if ((state_reg == IDLE) && im_kill) begin
         im_have_next = 1'b0;
      end
      if (im_xact && im_kill) begin
         kill_pend_next = 1'b1;
      end
      if (rsp_take) begin
         if (owner_reg == OWN_DM) begin
            dm_have_next = 1'b1;
         end else begin
            if (!im_discard) begin
               im_have_next = 1'b1;
            end
            kill_pend_next = 1'b0;
         end
      end
   end

   // Flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im_have_reg   <= 1'b0;
         dm_have_reg   <= 1'b0;
         kill_pend_reg <= 1'b0;
      end else begin
         im_have_reg   <= im_have_next;
         dm_have_reg   <= dm_have_next;
         kill_pend_reg <= kill_pend_next;
      end
   end

   // Response data: steer to the owner; a killed fetch leaves the old instruction in place.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         im_rdata_reg <= '0;
         dm_rdata_reg <= '0;
      end else if (rsp_take) begin
         if (owner_reg == OWN_DM) begin
            dm_rdata_reg <= mem.mem_rdata;
         end else if (!im_discard) begin
            im_rdata_reg <= mem.mem_rdata;
         end
      end
   end

   assign mem.mem_req   = mem_req_c;
   assign mem.mem_we    = mem_we_reg;
   assign mem.mem_wstrb = mem_wstrb_reg;
   assign mem.mem_addr  = mem_addr_reg;
   assign mem.mem_wdata = mem_wdata_reg;

   assign im_rdata      = im_rdata_reg;
   assign dm_rdata      = dm_rdata_reg;

`ifdef CPU_MEM_ARB_PERF_EN
   cpu_mem_arb_perf u_perf (
      .clk               (clk),
      .reset             (reset),
      .im_stall          (im_stall),
      .dm_stall          (dm_stall),
      .rvalid            (mem.mem_rvalid),
      .perf_im_stall_cnt (perf_im_stall_cnt),
      .perf_dm_stall_cnt (perf_dm_stall_cnt),
      .perf_xact_cnt     (perf_xact_cnt)
   );
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: a small memory responder with programmable
// grant and response delays, and a linear sequence of steps with hand-computed expectations.
module tb_cpu_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_kill;
   logic [31:0] im_rdata;
   logic        im_stall;
   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_wstrb;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_stall;
`ifdef CPU_MEM_ARB_PERF_EN
   logic [31:0] perf_im_stall_cnt;
   logic [31:0] perf_dm_stall_cnt;
   logic [31:0] perf_xact_cnt;
`endif

   int checks = 0;
   int errors = 0;

   int gnt_delay = 0;
   int rsp_delay = 0;

   int          req_cycles = 0;
   bit          rsp_pend   = 0;
   int          rsp_wait   = 0;
   logic [31:0] rsp_word   = '0;

   cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

   cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .im_req   (im_req),
      .im_addr  (im_addr),
      .im_kill  (im_kill),
      .im_rdata (im_rdata),
      .im_stall (im_stall),
      .dm_req   (dm_req),
      .dm_we    (dm_we),
      .dm_wstrb (dm_wstrb),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_rdata (dm_rdata),
      .dm_stall (dm_stall),
      .mem      (mem_bus)
`ifdef CPU_MEM_ARB_PERF_EN
      ,
      .perf_im_stall_cnt (perf_im_stall_cnt),
      .perf_dm_stall_cnt (perf_dm_stall_cnt),
      .perf_xact_cnt     (perf_xact_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Contents of the memory behind the arbiter.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0100: return 32'h0050_0093;
         32'h0000_0104: return 32'h00A0_0113;
         32'h0000_0200: return 32'h1234_5678;
         32'h0000_2000: return 32'hCAFE_F00D;
         32'h0000_2004: return 32'h0BAD_C0DE;
         default:       return a ^ 32'h5A5A_5A5A;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One step: move to the next falling edge, then settle inputs 1 time unit later.
   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   // Memory responder: grants after gnt_delay request cycles, answers rsp_delay cycles after the one-cycle minimum.
   initial begin
      mem_bus.mem_gnt    = 1'b0;
      mem_bus.mem_rvalid = 1'b0;
      mem_bus.mem_rdata  = '0;
      forever begin
         @(negedge clk);
         mem_bus.mem_gnt    = 1'b0;
         mem_bus.mem_rvalid = 1'b0;
         if (rsp_pend) begin
            if (rsp_wait == 0) begin
               mem_bus.mem_rvalid = 1'b1;
               mem_bus.mem_rdata  = rsp_word;
               rsp_pend           = 1'b0;
            end else begin
               rsp_wait--;
            end
         end
         if (mem_bus.mem_req && !rsp_pend) begin
            if (req_cycles >= gnt_delay) begin
               mem_bus.mem_gnt = 1'b1;
               rsp_pend        = 1'b1;
               rsp_wait        = rsp_delay;
               rsp_word        = mem_word(mem_bus.mem_addr);
               req_cycles      = 0;
            end else begin
               req_cycles++;
            end
         end
      end
   end

   initial begin
      reset    = 1'b1;
      im_req   = 1'b0;
      im_addr  = '0;
      im_kill  = 1'b0;
      dm_req   = 1'b0;
      dm_we    = 1'b0;
      dm_wstrb = '0;
      dm_addr  = '0;
      dm_wdata = '0;

      // Reset state
      cyc();
      cyc();
      chk("rst_mem_req",   mem_bus.mem_req,   32'd0);
      chk("rst_mem_we",    mem_bus.mem_we,    32'd0);
      chk("rst_mem_wstrb", mem_bus.mem_wstrb, 32'd0);
      chk("rst_mem_addr",  mem_bus.mem_addr,  32'd0);
      chk("rst_mem_wdata", mem_bus.mem_wdata, 32'd0);
      chk("rst_im_rdata",  im_rdata,          32'd0);
      chk("rst_dm_rdata",  dm_rdata,          32'd0);
      chk("rst_im_stall",  im_stall,          32'd0);
      chk("rst_dm_stall",  dm_stall,          32'd0);
`ifdef CPU_MEM_ARB_PERF_EN
      chk("rst_perf_xact", perf_xact_cnt,     32'd0);
`endif
      reset = 1'b0;
      $display("step reset: done");

      // 1: single fetch at minimum latency, stall high for three cycles
      cyc();
      im_req  = 1'b1;
      im_addr = 32'h100;
      #1;
      chk("t1_stall_c0", im_stall, 32'd1);
      chk("t1_req_c0",   mem_bus.mem_req, 32'd0);
      cyc();
      chk("t1_req_c1",   mem_bus.mem_req,  32'd1);
      chk("t1_addr_c1",  mem_bus.mem_addr, 32'h100);
      chk("t1_we_c1",    mem_bus.mem_we,   32'd0);
      chk("t1_stall_c1", im_stall,         32'd1);
      cyc();
      chk("t1_req_c2",   mem_bus.mem_req,  32'd0);
      chk("t1_stall_c2", im_stall,         32'd1);
      cyc();
      chk("t1_stall_c3", im_stall,         32'd0);
      chk("t1_rdata",    im_rdata,         32'h0050_0093);
      im_req = 1'b0;
      $display("step t1: fetch 0x100 -> %h", im_rdata);

      // 2: simultaneous fetch and load, data first
      cyc();
      im_req  = 1'b1;
      im_addr = 32'h100;
      dm_req  = 1'b1;
      dm_we   = 1'b0;
      dm_addr = 32'h2000;
      #1;
      chk("t2_im_stall_c0", im_stall, 32'd1);
      chk("t2_dm_stall_c0", dm_stall, 32'd1);
      cyc();
      chk("t2_addr_first", mem_bus.mem_addr, 32'h2000);
      chk("t2_req_first",  mem_bus.mem_req,  32'd1);
      cyc();
      chk("t2_im_stall_c2", im_stall, 32'd1);
      chk("t2_dm_stall_c2", dm_stall, 32'd1);
      cyc();
      chk("t2_dm_stall_c3", dm_stall, 32'd0);
      chk("t2_im_stall_c3", im_stall, 32'd1);
      chk("t2_dm_rdata",    dm_rdata, 32'hCAFE_F00D);
      cyc();
      chk("t2_addr_second", mem_bus.mem_addr, 32'h100);
      chk("t2_req_second",  mem_bus.mem_req,  32'd1);
      chk("t2_dm_stall_c4", dm_stall, 32'd0);
      cyc();
      chk("t2_im_stall_c5", im_stall, 32'd1);
      cyc();
      chk("t2_im_stall_c6", im_stall, 32'd0);
      chk("t2_dm_stall_c6", dm_stall, 32'd0);
      chk("t2_im_rdata",    im_rdata, 32'h0050_0093);
      im_req = 1'b0;
      dm_req = 1'b0;
      $display("step t2: dm %h then im %h", dm_rdata, im_rdata);

      // 3: store with grant withheld five cycles; requester changes are ignored
      cyc();
      gnt_delay = 5;
      dm_req    = 1'b1;
      dm_we     = 1'b1;
      dm_wstrb  = 4'b0011;
      dm_addr   = 32'h3000;
      dm_wdata  = 32'hDEAD_BEEF;
      #1;
      chk("t3_stall_c0", dm_stall, 32'd1);
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("t3_req",   mem_bus.mem_req,   32'd1);
         chk("t3_we",    mem_bus.mem_we,    32'd1);
         chk("t3_wstrb", mem_bus.mem_wstrb, 32'h3);
         chk("t3_wdata", mem_bus.mem_wdata, 32'hDEAD_BEEF);
         chk("t3_addr",  mem_bus.mem_addr,  32'h3000);
         chk("t3_stall", dm_stall,          32'd1);
         if (i == 1) begin
            dm_wdata = 32'h0;
            dm_wstrb = 4'hF;
            dm_addr  = 32'h3004;
         end
      end
      cyc();
      chk("t3_req_wait",   mem_bus.mem_req, 32'd0);
      chk("t3_stall_wait", dm_stall,        32'd1);
      cyc();
      chk("t3_stall_done", dm_stall,        32'd0);
      dm_req    = 1'b0;
      dm_we     = 1'b0;
      dm_wstrb  = '0;
      gnt_delay = 0;
      $display("step t3: store 0x3000 acked");

      // 4: fetch killed while waiting for its response, then refetch from branch target
      cyc();
      rsp_delay = 2;
      im_req    = 1'b1;
      im_addr   = 32'h200;
      cyc();
      chk("t4_addr", mem_bus.mem_addr, 32'h200);
      cyc();
      im_kill = 1'b1;
      #1;
      chk("t4_stall_kill", im_stall, 32'd1);
      cyc();
      im_kill = 1'b0;
      im_addr = 32'h104;
      cyc();
      chk("t4_stall_rsp", im_stall, 32'd1);
      cyc();
      chk("t4_stall_after", im_stall, 32'd1);
      chk("t4_rdata_kept",  im_rdata, 32'h0050_0093);
      rsp_delay = 0;
      cyc();
      chk("t4_refetch_req",  mem_bus.mem_req,  32'd1);
      chk("t4_refetch_addr", mem_bus.mem_addr, 32'h104);
      cyc();
      cyc();
      chk("t4_refetch_stall", im_stall, 32'd0);
      chk("t4_refetch_rdata", im_rdata, 32'h00A0_0113);
      im_req = 1'b0;
      $display("step t4: killed fetch dropped, refetch -> %h", im_rdata);

      // 5: reset during WAIT, late response ignored
      cyc();
      rsp_delay = 2;
      dm_req    = 1'b1;
      dm_addr   = 32'h2000;
      cyc();
      chk("t5_req", mem_bus.mem_req, 32'd1);
      cyc();
      reset  = 1'b1;
      dm_req = 1'b0;
      #1;
      chk("t5_rst_req",      mem_bus.mem_req,  32'd0);
      chk("t5_rst_addr",     mem_bus.mem_addr, 32'd0);
      chk("t5_rst_dm_rdata", dm_rdata,         32'd0);
      chk("t5_rst_im_rdata", im_rdata,         32'd0);
      cyc();
      reset     = 1'b0;
      rsp_delay = 0;
      cyc();
      chk("t5_late_rvalid", mem_bus.mem_rvalid, 32'd1);
      cyc();
      chk("t5_late_dm_rdata", dm_rdata,        32'd0);
      chk("t5_late_req",      mem_bus.mem_req, 32'd0);
      dm_req = 1'b1;
      cyc();
      chk("t5_new_addr", mem_bus.mem_addr, 32'h2000);
      cyc();
      cyc();
      chk("t5_new_stall", dm_stall, 32'd0);
      chk("t5_new_rdata", dm_rdata, 32'hCAFE_F00D);
      dm_req = 1'b0;
      $display("step t5: reset mid-transaction recovered, dm %h", dm_rdata);

      // 6: two loads, 7 + 3 data stall cycles, after a fresh reset
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
      gnt_delay = 4;
      dm_req    = 1'b1;
      dm_addr   = 32'h2004;
      repeat (7) cyc();
      chk("t6_stall_a", dm_stall, 32'd0);
      chk("t6_rdata_a", dm_rdata, 32'h0BAD_C0DE);
      dm_req    = 1'b0;
      gnt_delay = 0;
      cyc();
      dm_req  = 1'b1;
      dm_addr = 32'h2000;
      repeat (3) cyc();
      chk("t6_stall_b", dm_stall, 32'd0);
      chk("t6_rdata_b", dm_rdata, 32'hCAFE_F00D);
      dm_req = 1'b0;
      cyc();
`ifdef CPU_MEM_ARB_PERF_EN
      chk("t6_perf_dm",   perf_dm_stall_cnt, 32'd10);
      chk("t6_perf_xact", perf_xact_cnt,     32'd2);
      chk("t6_perf_im",   perf_im_stall_cnt, 32'd0);
`endif
      $display("step t6: two loads done");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
